multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Main sequencer for the multicycle MIPS-subset datapath. Decodes the latched instruction opcode.
//  Steps the datapath through fetch/decode/execute/memory/writeback.
//  Drives the datapath mux selects and write strobes, plus the 3-bit ALU op consumed by the ALU control
//  decoder. Handshakes with a variable-latency unified memory. Counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  opcode         in   6      instr[31:26] from instruction register
//  mem_ready      in   1      memory completes current read/write this cycle
//  zero           in   1      ALU zero flag (branch compare)
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load if zero
//  ir_write       out  1      instruction register load
//  iord           out  1      0=PC addresses memory, 1=ALUOut
//  mem_read       out  1      memory read request
//  mem_write      out  1      memory write request
//  reg_write      out  1      register file write
//  reg_dst        out  1      0=rt, 1=rd
//  mem_to_reg     out  1      0=ALUOut, 1=MDR
//  alu_src_a      out  1      0=PC, 1=rs
//  alu_src_b      out  2      00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
//  pc_source      out  2      00=ALU, 01=ALUOut, 10=jump target
//  alu_op         out  3      000 add, 001 sub, 010 and, 011 or, 100 R-type funct
//  illegal        out  1      sticky: unsupported opcode decoded
//  retired        out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset: state=FETCH, retired=0, illegal=0. All strobes are forced 0 while rst_n low.
//  - Outputs are combinational from state; fetch/memory strobes are additionally qualified by mem_ready where noted.
//  - FETCH: mem_read=1, iord=0, src_a=0, src_b=01, alu_op=000.
//    ir_write and pc_write pulse only in the mem_ready cycle.
//    Hold in FETCH while mem_ready=0, then go to DECODE.
//  - DECODE: src_a=0, src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
//    000000->R_EXEC; 100011/101011->MEM_ADDR; 000100->BRANCH; 000010->JUMP; other->TRAP.
//  - MEM_ADDR: src_a=1, src_b=10, alu_op=000. Go to MEM_RD for lw, MEM_WR for sw.
//  - MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then MEM_WB.
//  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
//  - MEM_WR: mem_write=1, iord=1. Hold until mem_ready, then FETCH.
//  - R_EXEC: src_a=1, src_b=00, alu_op=100. Then R_WB.
//  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
//  - BRANCH: src_a=1, src_b=00, alu_op=001, pc_source=01, pc_write_cond=1. Then FETCH.
//  - JUMP: pc_source=10, pc_write=1. Then FETCH.
//  - TRAP: illegal=1. No strobes. Terminal until rst_n.
//  - Every instruction returns to FETCH through exactly one retire cycle:
//    MEM_WB, MEM_WR&&mem_ready, R_WB, BRANCH, JUMP (and I_WB when present).
//    retired += 1 on that cycle and wraps modulo 2^CNT_W.
//  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored. Memory latency is unbounded; no timeout.
//  - Async reset mid-instruction aborts it. Nothing is retired; FETCH restarts after release.
//  - Unused select outputs are 0 in states that do not name them.
// CONFIGURATION
//  IMM_ALU_EN defined: DECODE also maps 001000 addi, 001100 andi, 001101 ori -> I_EXEC.
//    I_EXEC: src_a=1, src_b=10, alu_op=000/010/011 respectively. Then I_WB.
//    I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH, retire.
//  IMM_ALU_EN undefined: those opcodes go to TRAP; the I_EXEC/I_WB states do not exist.
// STRUCTURE
//  - Shared package mips_ctrl_pkg: opcode localparams, alu_op encodings (shared with ALU control decoder),
//    state encoding (4-bit), alu_src_b/pc_source encodings.
//  - Single module. The state register, next-state logic, output decode and retire counter are all local.
//    No sub-module.
// TESTING
//  1. Reset mid-MEM_RD: rst_n low in MEM_RD -> state FETCH, retired=0, all strobes 0 during reset.
//  2. R-type, opcode 000000, mem_ready after 3 wait cycles:
//     FETCH x4, DECODE, R_EXEC (alu_op=100), R_WB (reg_write=1, reg_dst=1); retired 0->1.
//  3. lw 100011, mem_ready=1 immediately:
//     MEM_ADDR (src_b=10), MEM_RD (iord=1), MEM_WB (mem_to_reg=1); 5 cycles total.
//  4. sw 101011, mem_ready delayed 2 cycles in MEM_WR: mem_write held 3 cycles; retire on the ready cycle only.
//  5. beq 000100 with zero=1, then with zero=0:
//     BRANCH alu_op=001, pc_write_cond=1, pc_source=01; 3 cycles each.
//  6. Opcode 111111 -> TRAP, illegal=1 sticky for 20 cycles, no strobes.
//     With IMM_ALU_EN, ori 001101 -> I_EXEC alu_op=011, then I_WB.
//     Preload retired=2^CNT_W-1 -> wraps to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path.
// Optional immediate-ALU instructions are enabled with `define IMM_ALU_EN.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   // alu_op values, also decoded by the ALU control unit
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_FUNCT = 3'b100;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
`ifdef IMM_ALU_EN
      S_TRAP     = 4'd10,
      S_I_EXEC   = 4'd11,
      S_I_WB     = 4'd12
`else
      S_TRAP     = 4'd10
`endif
   } state_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath/memory signal bundle; master is the sequencer.
interface multicycle_control_if #(parameter int CNT_W = 32);
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             zero;
   logic             pc_write;
   logic             pc_write_cond;
   logic             ir_write;
   logic             iord;
   logic             mem_read;
   logic             mem_write;
   logic             reg_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       pc_source;
   logic [2:0]       alu_op;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  opcode, mem_ready, zero,
      output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
             reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source,
             alu_op, illegal, retired
   );

   modport slave (
      output opcode, mem_ready, zero,
      input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
             reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source,
             alu_op, illegal, retired
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset sequencer: FSM, output decode and retire counter.
// `define IMM_ALU_EN adds addi/andi/ori via I_EXEC/I_WB.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic clk,
   input  logic rst_n,
   multicycle_control_if.master ctl_if
);

   state_e           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;
   ctrl_t            ctrl_raw, ctrl;

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:    if (ctl_if.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (ctl_if.opcode)
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
`ifdef IMM_ALU_EN
               OP_ADDI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
`endif
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEM_ADDR: state_d = (ctl_if.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (ctl_if.mem_ready) state_d = S_MEM_WB;
         S_MEM_WB:   begin state_d = S_FETCH; retire = 1'b1; end
         S_MEM_WR: begin
            if (ctl_if.mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_R_EXEC:   state_d = S_R_WB;
         S_R_WB:     begin state_d = S_FETCH; retire = 1'b1; end
         S_BRANCH:   begin state_d = S_FETCH; retire = 1'b1; end
         S_JUMP:     begin state_d = S_FETCH; retire = 1'b1; end
         S_TRAP:     state_d = S_TRAP;
`ifdef IMM_ALU_EN
         S_I_EXEC:   state_d = S_I_WB;
         S_I_WB:     begin state_d = S_FETCH; retire = 1'b1; end
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   assign illegal_d = illegal_q | (state_d == S_TRAP);
   assign retired_d = retired_q + CNT_W'(retire);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      ctrl_raw = '0;
      case (state_q)
         S_FETCH: begin
            ctrl_raw.mem_read  = 1'b1;
            ctrl_raw.alu_src_b = SRCB_FOUR;
            ctrl_raw.alu_op    = ALU_ADD;
            // IR and PC only load once the fetched word is actually on the bus
            ctrl_raw.ir_write  = ctl_if.mem_ready;
            ctrl_raw.pc_write  = ctl_if.mem_ready;
         end
         S_DECODE: begin
            ctrl_raw.alu_src_b = SRCB_IMM_SH;
            ctrl_raw.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR: begin
            ctrl_raw.alu_src_a = 1'b1;
            ctrl_raw.alu_src_b = SRCB_IMM;
            ctrl_raw.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            ctrl_raw.mem_read = 1'b1;
            ctrl_raw.iord     = 1'b1;
         end
         S_MEM_WB: begin
            ctrl_raw.reg_write  = 1'b1;
            ctrl_raw.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl_raw.mem_write = 1'b1;
            ctrl_raw.iord      = 1'b1;
         end
         S_R_EXEC: begin
            ctrl_raw.alu_src_a = 1'b1;
            ctrl_raw.alu_src_b = SRCB_RT;
            ctrl_raw.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl_raw.reg_write = 1'b1;
            ctrl_raw.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl_raw.alu_src_a     = 1'b1;
            ctrl_raw.alu_src_b     = SRCB_RT;
            ctrl_raw.alu_op        = ALU_SUB;
            ctrl_raw.pc_source     = PCS_ALUOUT;
            ctrl_raw.pc_write_cond = 1'b1;
         end
         S_JUMP: begin
            ctrl_raw.pc_source = PCS_JUMP;
            ctrl_raw.pc_write  = 1'b1;
         end
`ifdef IMM_ALU_EN
         S_I_EXEC: begin
            ctrl_raw.alu_src_a = 1'b1;
            ctrl_raw.alu_src_b = SRCB_IMM;
            case (ctl_if.opcode)
               OP_ANDI: ctrl_raw.alu_op = ALU_AND;
               OP_ORI:  ctrl_raw.alu_op = ALU_OR;
               default: ctrl_raw.alu_op = ALU_ADD;
            endcase
         end
         S_I_WB: begin
            ctrl_raw.reg_write = 1'b1;
         end
`endif
         default: ctrl_raw = '0;
      endcase
   end

   // reset holds state at FETCH, whose strobes must not reach memory meanwhile
   assign ctrl = rst_n ? ctrl_raw : '0;

   assign ctl_if.pc_write      = ctrl.pc_write;
   assign ctl_if.pc_write_cond = ctrl.pc_write_cond;
   assign ctl_if.ir_write      = ctrl.ir_write;
   assign ctl_if.iord          = ctrl.iord;
   assign ctl_if.mem_read      = ctrl.mem_read;
   assign ctl_if.mem_write     = ctrl.mem_write;
   assign ctl_if.reg_write     = ctrl.reg_write;
   assign ctl_if.reg_dst       = ctrl.reg_dst;
   assign ctl_if.mem_to_reg    = ctrl.mem_to_reg;
   assign ctl_if.alu_src_a     = ctrl.alu_src_a;
   assign ctl_if.alu_src_b     = ctrl.alu_src_b;
   assign ctl_if.pc_source     = ctrl.pc_source;
   assign ctl_if.alu_op        = ctrl.alu_op;
   assign ctl_if.illegal       = illegal_q;
   assign ctl_if.retired       = retired_q;

endmodule
